spike_layer: RTL

Parametrised rate-coded spiking layer: N_IN binary pixel inputs drive N_OUT integrate-and-fire output neurons through per-synapse signed weights. Each synapse turns its weight into a spike rate with a phase-accumulator divider. Each neuron integrates signed events, fires, and enters a refractory period. A windowed spike counter reports the winning output class. It replaces the single-output pixel network as the classifier core, sitting between the pixel front-end and the result interface.

---
 rtl/spike_layer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/spike_layer.sv
// spike_layer: rate-coded integrate-and-fire classifier layer.
// Pixels drive N_OUT neurons through signed sign-magnitude synapse weights.
// Each synapse converts its weight magnitude into an event rate with a
// phase accumulator; neurons integrate, fire and go refractory; a windowed
// spike counter reports the winning class.
// Optional membrane leak is compiled in with the macro SPIKE_LAYER_LEAK_EN.
module spike_layer #(
    parameter int N_IN        = 16,
    parameter int N_OUT       = 4,
    parameter int WIDTH       = 8,
    parameter logic [N_OUT*N_IN*(WIDTH+1)-1:0] WEIGHTS = '0,
    parameter int POT_W       = 16,
    parameter int THRESH      = 8,
    parameter int STIM_PERIOD = 4,
    parameter int REFRACT     = 2,
    parameter int WINDOW      = 64,
    parameter int COUNT_W     = 8,
    parameter int LEAK_SHIFT  = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         en,
    input  logic [N_IN-1:0]                              pixels,
    output logic [N_OUT-1:0]                             spikes_out,
    output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] winner,
    output logic                                         winner_valid,
    output logic                                         winner_none
);
    localparam int WIN_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int TICK_W = (STIM_PERIOD > 1) ? $clog2(STIM_PERIOD) : 1;
    localparam int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int REF_W  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam int EXT_W  = POT_W + 2;
    localparam int N_SYN  = N_OUT * N_IN;

    localparam logic signed [EXT_W-1:0] P_THR = EXT_W'(THRESH);
    localparam logic signed [EXT_W-1:0] P_MIN = -P_THR;
    localparam logic signed [EXT_W-1:0] P_MAX = {3'b000, {(POT_W-1){1'b1}}};
    localparam logic [COUNT_W-1:0]      C_MAX = '1;

`ifdef SPIKE_LAYER_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    logic [TICK_W-1:0]       tick_cnt;
    logic                    tick;
    logic                    upd;
    logic [WIDTH-1:0]        acc     [N_SYN];
    logic [WIDTH:0]          sum_v   [N_SYN];
    logic [N_SYN-1:0]        ev;
    logic signed [POT_W-1:0] pot     [N_OUT];
    logic signed [POT_W-1:0] shr_v   [N_OUT];
    logic signed [POT_W-1:0] base_v  [N_OUT];
    logic signed [POT_W-1:0] pot_nxt [N_OUT];
    logic signed [EXT_W-1:0] net_v   [N_OUT];
    logic signed [EXT_W-1:0] p_v     [N_OUT];
    logic [REF_W-1:0]        refr     [N_OUT];
    logic [REF_W-1:0]        refr_nxt [N_OUT];
    logic [N_OUT-1:0]        fire;
    logic [COUNT_W-1:0]      cnt [N_OUT];
    logic [WCNT_W-1:0]       win_cnt;
    logic                    win_pend;
    logic [WIN_W-1:0]        best;
    logic                    none;

    assign tick = en && (tick_cnt == TICK_W'(STIM_PERIOD - 1));

    // Stimulus tick generator; frozen while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (en) begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    // Neuron updates run the cycle after a tick, independent of en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) upd <= 1'b0;
        else      upd <= tick;
    end

    // Phase-accumulator sums: carry out of the WIDTH-bit accumulator is the event.
    always_comb begin
        for (int k = 0; k < N_SYN; k++) begin
            sum_v[k] = {1'b0, acc[k]} + {1'b0, WEIGHTS[k*(WIDTH+1) +: WIDTH]};
        end
    end

    // Synapse accumulators and registered events.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_SYN; k++) acc[k] <= '0;
            ev <= '0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                for (int i = 0; i < N_IN; i++) begin
                    ev[j*N_IN+i] <= 1'b0;
                    if (tick && pixels[i]) begin
                        acc[j*N_IN+i] <= sum_v[j*N_IN+i][WIDTH-1:0];
                        ev[j*N_IN+i]  <= sum_v[j*N_IN+i][WIDTH];
                    end
                end
            end
        end
    end

    // Neuron integrate/clamp/fire/refractory next state.
    always_comb begin
        fire = '0;
        for (int j = 0; j < N_OUT; j++) begin
            net_v[j] = '0;
            for (int i = 0; i < N_IN; i++) begin
                if (ev[j*N_IN+i]) begin
                    if (WEIGHTS[(j*N_IN+i)*(WIDTH+1)+WIDTH]) net_v[j] = net_v[j] - EXT_W'(1);
                    else                                     net_v[j] = net_v[j] + EXT_W'(1);
                end
            end
            // A small positive potential whose shifted leak rounds to zero
            // still decays by one; negative shifts never round to zero.
            shr_v[j] = pot[j] >>> LEAK_SHIFT;
            if (!LEAK_ON)                                base_v[j] = pot[j];
            else if (pot[j] != '0 && shr_v[j] == '0)    base_v[j] = pot[j] - POT_W'(1);
            else                                         base_v[j] = pot[j] - shr_v[j];
            p_v[j] = EXT_W'(base_v[j]) + net_v[j];
            if (p_v[j] < P_MIN)      p_v[j] = P_MIN;
            else if (p_v[j] > P_MAX) p_v[j] = P_MAX;

            pot_nxt[j]  = pot[j];
            refr_nxt[j] = refr[j];
            if (upd) begin
                if (refr[j] != '0) begin
                    refr_nxt[j] = refr[j] - REF_W'(1);
                end else if (p_v[j] >= P_THR) begin
                    fire[j]     = 1'b1;
                    pot_nxt[j]  = '0;
                    refr_nxt[j] = REF_W'(REFRACT);
                end else begin
                    pot_nxt[j] = p_v[j][POT_W-1:0];
                end
            end
        end
    end

    // Neuron state, fire pulses and saturating spike counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spikes_out <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                pot[j]  <= '0;
                refr[j] <= '0;
                cnt[j]  <= '0;
            end
        end else begin
            spikes_out <= fire;
            for (int j = 0; j < N_OUT; j++) begin
                pot[j]  <= pot_nxt[j];
                refr[j] <= refr_nxt[j];
                if (win_pend)                      cnt[j] <= '0;
                else if (fire[j] && cnt[j] != C_MAX) cnt[j] <= cnt[j] + COUNT_W'(1);
            end
        end
    end

    // Window counter advances once per neuron update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt  <= '0;
            win_pend <= 1'b0;
        end else begin
            win_pend <= 1'b0;
            if (upd) begin
                if (win_cnt == WCNT_W'(WINDOW - 1)) begin
                    win_cnt  <= '0;
                    win_pend <= 1'b1;
                end else begin
                    win_cnt <= win_cnt + WCNT_W'(1);
                end
            end
        end
    end

    // Argmax of spike counts, lowest index wins ties.
    always_comb begin
        best = '0;
        none = 1'b1;
        for (int j = 0; j < N_OUT; j++) begin
            if (cnt[j] != '0)       none = 1'b0;
            if (cnt[j] > cnt[best]) best = WIN_W'(j);
        end
    end

    // Winner registers, loaded once per window end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            winner       <= '0;
            winner_none  <= 1'b0;
            winner_valid <= 1'b0;
        end else begin
            winner_valid <= win_pend;
            if (win_pend) begin
                winner      <= best;
                winner_none <= none;
            end
        end
    end

endmodule
